gshare_predictor: RTL
=====================

# gshare_predictor

Global-history (gshare) direction predictor for the lab4 branch pipeline. Fetch sends lookup requests over a val/rdy port and receives one registered taken/not-taken response per request. Execute writes resolved outcomes back through an update port. All table and history state lives in synchronously reset, enabled flops built from the team's enable/reset register primitive.

## Interface
- p_index_bits, 6, log2 of table entries; table depth is 2**p_index_bits.
- p_ghr_bits, 6, global history length; legal range 1..p_index_bits.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset: synchronous, active-high.
- req_val  in  1  lookup request valid.
- req_rdy  out  1  lookup request ready.
- req_pc  in  32  PC of the branch being predicted.
- resp_val  out  1  prediction valid.
- resp_rdy  in  1  consumer ready for prediction.
- resp_taken  out  1  predicted direction, 1 = taken.
- resp_idx  out  p_index_bits  table index used; returned unchanged on update.
- upd_val  in  1  resolved-branch update valid; no backpressure, always accepted.
- upd_idx  in  p_index_bits  index from the matching response.
- upd_taken  in  1  actual outcome.

## Operation
- Table: 2**p_index_bits 2-bit saturating counters. Reset value is 2'b01 (weakly not-taken) for every entry.
- GHR: p_ghr_bits shift register, reset value 0.
- Lookup index = req_pc[p_index_bits+1:2] XOR zero-extended GHR. The GHR occupies the low bits.
- Request accepted when req_val && req_rdy. The response register then captures resp_taken = counter[idx][1] and resp_idx = idx.
- req_rdy = !resp_val || resp_rdy. This gives a single-entry output buffer with full-throughput pass-through.
- While resp_val && !resp_rdy, resp_taken and resp_idx hold stable.
- Update on upd_val:
  - counter[upd_idx] increments when upd_taken and the counter is below 3.
  - It decrements when !upd_taken and the counter is above 0.
  - The counter saturates at 3 and at 0.
  - GHR <= {GHR[p_ghr_bits-2:0], upd_taken}, with the newest outcome in bit 0. When p_ghr_bits = 1, GHR <= upd_taken.
- GHR is non-speculative: it changes only on update, never on lookup.
- An update and a lookup in the same cycle are independent. Ordering depends on the Configuration macro.

## Timing
- Reset outputs:
  - resp_val = 0.
  - resp_taken = 0.
  - resp_idx = 0.
  - req_rdy = 1 in the first cycle after reset.
- Lookup latency: a request accepted in cycle N gives resp_val = 1 in cycle N+1.
- Back-to-back requests sustain 1 per cycle while resp_rdy = 1.
- Update latency: a counter or GHR written in cycle N is visible to lookups accepted in cycle N+1 or later.
- Reset asserted mid-operation: at the next edge it drops any pending response, restores all counters to 01 and the GHR to 0, and ignores any req or upd in that cycle.
- Response held under backpressure is not recomputed. It keeps the counter value sampled at acceptance, even if later updates change that entry.

## Configuration
- GSHARE_BYPASS_EN:
  - Defined: a same-cycle upd_val forwards into the lookup. Index and response use the post-update GHR and post-update counter, so the result equals the response one cycle later.
  - Undefined: the same-cycle lookup sees pre-update GHR and counter values.

## Test plan
- Reset, then lookup pc=0x100 with resp_rdy=1 -> cycle+1 gives resp_val=1, resp_taken=0, resp_idx=0x00.
- Three updates idx=0x05 taken, with no interleaved lookups:
  - The counter goes 01->10->11->11 (saturates).
  - GHR = 0b000111.
  - A lookup whose index resolves to 0x05 returns resp_taken=1.
- Four updates idx=0x03 not-taken -> counter saturates at 00. One taken update -> 01, and a lookup returns resp_taken=0.
- Backpressure:
  - Lookup accepted with resp_rdy=0 -> resp held 3 cycles and req_rdy=0 throughout.
  - Raise resp_rdy with a new req_val -> handoff completes and the next response appears in the following cycle.
- Same-cycle update taken on idx X and lookup hitting X, starting from counter 01:
  - Without GSHARE_BYPASS_EN, resp_taken=0.
  - With GSHARE_BYPASS_EN, resp_taken=1 and resp_idx reflects the shifted GHR.
- Reset asserted while resp_val=1 and resp_rdy=0 -> next cycle resp_val=0 and all counters read back 01.

Source files
------------

// File: rtl/gshare_predictor.sv
// gshare direction predictor: PC xor global history indexes a table of 2-bit counters.
// Optional build macro GSHARE_BYPASS_EN forwards a same-cycle update into the lookup.

module gshare_predictor_reg #(
  parameter int                 p_width       = 1,
  parameter logic [p_width-1:0] p_reset_value = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [p_width-1:0] d,
  output logic [p_width-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= p_reset_value;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

module gshare_predictor #(
  parameter int p_index_bits = 6,
  parameter int p_ghr_bits   = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_val,
  output logic                    req_rdy,
  input  logic [31:0]             req_pc,
  output logic                    resp_val,
  input  logic                    resp_rdy,
  output logic                    resp_taken,
  output logic [p_index_bits-1:0] resp_idx,
  input  logic                    upd_val,
  input  logic [p_index_bits-1:0] upd_idx,
  input  logic                    upd_taken
);

  localparam int depth = 2 ** p_index_bits;

  logic [1:0]              ctr_q [depth];
  logic [depth-1:0]        ctr_en;
  logic [1:0]              ctr_d;
  logic [p_ghr_bits-1:0]   ghr_q;
  logic [p_ghr_bits-1:0]   ghr_d;
  logic [p_ghr_bits-1:0]   ghr_shift;
  logic [p_ghr_bits-1:0]   ghr_look;
  logic [p_index_bits-1:0] ghr_ext;
  logic [p_index_bits-1:0] look_idx;
  logic                    look_taken;
  logic                    req_fire;
  logic                    resp_val_q;
  logic                    resp_val_d;
  logic                    resp_taken_q;
  logic                    resp_taken_d;
  logic [p_index_bits-1:0] resp_idx_q;
  logic [p_index_bits-1:0] resp_idx_d;
  logic                    unused_pc;

  assign unused_pc = ^{req_pc[31:p_index_bits+2], req_pc[1:0]};

  function automatic logic [1:0] sat_next(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken && cur != 2'b11) begin
      nxt = cur + 2'd1;
    end else if (!taken && cur != 2'b00) begin
      nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

  generate
    if (p_ghr_bits == 1) begin : g_ghr_one
      assign ghr_shift = upd_taken;
    end else begin : g_ghr_many
      assign ghr_shift = {ghr_q[p_ghr_bits-2:0], upd_taken};
    end
  endgenerate

  // Only the addressed counter is enabled, so a single shared next value suffices.
  always_comb begin
    ctr_en = '0;
    ctr_d  = sat_next(ctr_q[upd_idx], upd_taken);
    ghr_d  = ghr_q;
    if (upd_val) begin
      ctr_en[upd_idx] = 1'b1;
      ghr_d           = ghr_shift;
    end
  end

  always_comb begin
`ifdef GSHARE_BYPASS_EN
    ghr_look = ghr_d;
`else
    ghr_look = ghr_q;
`endif
    ghr_ext                   = '0;
    ghr_ext[p_ghr_bits-1:0]   = ghr_look;
    look_idx                  = req_pc[p_index_bits+1:2] ^ ghr_ext;
    look_taken                = ctr_q[look_idx][1];
`ifdef GSHARE_BYPASS_EN
    if (upd_val && upd_idx == look_idx) begin
      look_taken = ctr_d[1];
    end
`endif
  end

  assign req_rdy  = !resp_val_q || resp_rdy;
  assign req_fire = req_val && req_rdy;

  // The response is sampled once at acceptance and then held until consumed.
  always_comb begin
    resp_val_d   = resp_val_q;
    resp_taken_d = resp_taken_q;
    resp_idx_d   = resp_idx_q;
    if (req_fire) begin
      resp_val_d   = 1'b1;
      resp_taken_d = look_taken;
      resp_idx_d   = look_idx;
    end else if (resp_rdy) begin
      resp_val_d   = 1'b0;
    end
  end

  generate
    for (genvar i = 0; i < depth; i++) begin : g_ctr
      gshare_predictor_reg #(
        .p_width       (2),
        .p_reset_value (2'b01)
      ) u_ctr (
        .clk   (clk),
        .reset (reset),
        .en    (ctr_en[i]),
        .d     (ctr_d),
        .q     (ctr_q[i])
      );
    end
  endgenerate

  gshare_predictor_reg #(.p_width(p_ghr_bits)) u_ghr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (ghr_d),
    .q     (ghr_q)
  );

  gshare_predictor_reg #(.p_width(1)) u_resp_val (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (resp_val_d),
    .q     (resp_val_q)
  );

  gshare_predictor_reg #(.p_width(1)) u_resp_taken (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (resp_taken_d),
    .q     (resp_taken_q)
  );

  gshare_predictor_reg #(.p_width(p_index_bits)) u_resp_idx (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (resp_idx_d),
    .q     (resp_idx_q)
  );

  assign resp_val   = resp_val_q;
  assign resp_taken = resp_taken_q;
  assign resp_idx   = resp_idx_q;

endmodule
